// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, overlap/non-overlap modes and saturating match counter.
// valid_o is a registered Moore flag, high the cycle after the edge that samples the final pattern bit; no backpressure.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b1010,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             string_i,
    input  logic             string_vld_i,
    input  logic             overlap_i,
    input  logic             cfg_load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             cnt_clr_i,
    output logic             valid_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int             FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {HUNT, MATCH} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             samp;
    logic             hit;
    logic [PAT_W-1:0] hist_sh;
    logic [FW-1:0]    fill_inc;

    always_comb begin
        samp     = string_vld_i & ~cfg_load_i;
        hist_sh  = {hist_q[PAT_W-2:0], string_i};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        // The fill check keeps the zeroed reset history from matching an all-zero pattern early.
        hit      = samp && (fill_inc == FILL_FULL) && (hist_sh == pat_q);

        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = hit ? MATCH : HUNT;
        cnt_d   = cnt_q;

        if (cfg_load_i) begin
            pat_d  = pattern_i;
            hist_d = '0;
            fill_d = '0;
        end else if (samp) begin
            if (hit && !overlap_i) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_sh;
                fill_d = fill_inc;
            end
        end

        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HUNT;
            pat_q   <= RST_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = (state_q == MATCH);
    assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default, 6-bit pattern and 2-bit counter instances share stimulus.
module tb_seq_detect_param;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       string_i;
    logic       string_vld_i;
    logic       overlap_i;
    logic       cfg_load_i;
    logic [3:0] pat4_i;
    logic [5:0] pat6_i;
    logic       cnt_clr_i;

    logic       valid0, valid1, valid2;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    seq_detect_param dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .string_i(string_i), .string_vld_i(string_vld_i),
        .overlap_i(overlap_i), .cfg_load_i(cfg_load_i), .pattern_i(pat4_i),
        .cnt_clr_i(cnt_clr_i), .valid_o(valid0), .match_cnt_o(cnt0)
    );

    seq_detect_param #(.PAT_W(6), .RST_PAT(6'b101010), .CNT_W(8)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .string_i(string_i), .string_vld_i(string_vld_i),
        .overlap_i(overlap_i), .cfg_load_i(cfg_load_i), .pattern_i(pat6_i),
        .cnt_clr_i(cnt_clr_i), .valid_o(valid1), .match_cnt_o(cnt1)
    );

    seq_detect_param #(.PAT_W(4), .RST_PAT(4'b1010), .CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .string_i(string_i), .string_vld_i(string_vld_i),
        .overlap_i(overlap_i), .cfg_load_i(cfg_load_i), .pattern_i(pat4_i),
        .cnt_clr_i(cnt_clr_i), .valid_o(valid2), .match_cnt_o(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic cur_valid(input int which);
        case (which)
            1:       return valid1;
            2:       return valid2;
            default: return valid0;
        endcase
    endfunction

    // One clock: drive a bit, take the edge, sample 1 time unit later, then idle the strobes.
    task automatic step(input logic b, input logic v);
        string_i     = b;
        string_vld_i = v;
        @(posedge clk_i);
        #1;
        string_vld_i = 1'b0;
        cfg_load_i   = 1'b0;
        cnt_clr_i    = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] expv, input int which);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1);
            check($sformatf("%s_b%0d", tag, i + 1), {31'd0, cur_valid(which)}, {31'd0, expv[n-1-i]});
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst_ni = 1'b0;
        #2;
        check({tag, "_rst_v0"}, {31'd0, valid0}, 32'd0);
        check({tag, "_rst_c0"}, {24'd0, cnt0}, 32'd0);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        string_i     = 1'b0;
        string_vld_i = 1'b0;
        overlap_i    = 1'b1;
        cfg_load_i   = 1'b0;
        pat4_i       = 4'b1010;
        pat6_i       = 6'b110011;
        cnt_clr_i    = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        check("init_v0", {31'd0, valid0}, 32'd0);
        check("init_v1", {31'd0, valid1}, 32'd0);
        check("init_c0", {24'd0, cnt0}, 32'd0);
        check("init_c2", {30'd0, cnt2}, 32'd0);
        rst_ni = 1'b1;
        step(1'b0, 1'b0);
        check("post_rst_v0", {31'd0, valid0}, 32'd0);

        // Overlapping: matches after bits 4 and 6.
        overlap_i = 1'b1;
        run_seq("ovl", 6, 16'b101010, 16'b000101, 0);
        check("ovl_cnt", {24'd0, cnt0}, 32'd2);
        step(1'b0, 1'b0);
        check("ovl_idle_v", {31'd0, valid0}, 32'd0);
        check("ovl_idle_cnt", {24'd0, cnt0}, 32'd2);

        // Non-overlapping: single match, history restarts.
        pulse_reset("novl");
        overlap_i = 1'b0;
        run_seq("novl", 6, 16'b101010, 16'b000100, 0);
        check("novl_cnt", {24'd0, cnt0}, 32'd1);

        // Gaps of two idle cycles between sampled bits.
        pulse_reset("gap");
        overlap_i = 1'b1;
        step(1'b1, 1'b1); check("gap_b1", {31'd0, valid0}, 32'd0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); check("gap_g1", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b1); check("gap_b2", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b0); step(1'b0, 1'b0); check("gap_g2", {31'd0, valid0}, 32'd0);
        step(1'b1, 1'b1); check("gap_b3", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b0); check("gap_g3a", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b0); check("gap_g3b", {31'd0, valid0}, 32'd0);
        step(1'b0, 1'b1); check("gap_b4", {31'd0, valid0}, 32'd1);
        step(1'b0, 1'b0); check("gap_after", {31'd0, valid0}, 32'd0);
        check("gap_cnt", {24'd0, cnt0}, 32'd1);

        // Seven overlapping matches saturate the 2-bit counter; clear on a match edge wins.
        pulse_reset("sat");
        overlap_i = 1'b1;
        run_seq("sat", 16, 16'hAAAA, 16'h1555, 2);
        check("sat_c2", {30'd0, cnt2}, 32'd3);
        check("sat_c0", {24'd0, cnt0}, 32'd7);
        step(1'b1, 1'b1);
        cnt_clr_i = 1'b1;
        step(1'b0, 1'b1);
        check("clr_v2", {31'd0, valid2}, 32'd1);
        check("clr_c2", {30'd0, cnt2}, 32'd0);
        check("clr_c0", {24'd0, cnt0}, 32'd0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("clr_next_c2", {30'd0, cnt2}, 32'd1);
        check("clr_next_c0", {24'd0, cnt0}, 32'd1);

        // 6-bit pattern loaded while a bit is presented: that bit is discarded.
        pulse_reset("p6");
        pat4_i     = 4'b1010;
        pat6_i     = 6'b110011;
        cfg_load_i = 1'b1;
        step(1'b1, 1'b1);
        check("p6_load_v", {31'd0, valid1}, 32'd0);
        run_seq("p6_short", 5, 16'b10011, 16'b00000, 1);
        cfg_load_i = 1'b1;
        step(1'b1, 1'b1);
        run_seq("p6_full", 6, 16'b110011, 16'b000001, 1);
        check("p6_cnt", {24'd0, cnt1}, 32'd1);
        step(1'b0, 1'b0);
        check("p6_idle_v", {31'd0, valid1}, 32'd0);

        // Back-to-back matches keep valid high; all-zero pattern needs a full fill.
        pulse_reset("b2b");
        overlap_i  = 1'b1;
        pat4_i     = 4'b1111;
        cfg_load_i = 1'b1;
        step(1'b0, 1'b0);
        run_seq("b2b", 6, 16'b111111, 16'b000111, 0);
        check("b2b_cnt", {24'd0, cnt0}, 32'd3);
        pat4_i     = 4'b0000;
        cfg_load_i = 1'b1;
        step(1'b0, 1'b0);
        run_seq("zero", 5, 16'b00000, 16'b00011, 0);

        // Reset mid-sequence restores the reset pattern and empties history.
        pulse_reset("mid0");
        overlap_i  = 1'b0;
        pat4_i     = 4'b0101;
        cfg_load_i = 1'b1;
        step(1'b0, 1'b0);
        run_seq("ld0101", 4, 16'b0101, 16'b0001, 0);
        check("ld0101_cnt", {24'd0, cnt0}, 32'd1);
        run_seq("mid_pre", 3, 16'b101, 16'b000, 0);
        pulse_reset("mid");
        step(1'b0, 1'b1);
        check("mid_post_v", {31'd0, valid0}, 32'd0);
        run_seq("mid_pat", 4, 16'b1010, 16'b0001, 0);
        check("mid_cnt", {24'd0, cnt0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
